// File: rtl/seven_segments_scan_if.sv
// Multiplexed seven-segment display bus: one-hot digit select plus active-high segment lines.
// The display driver owns the bus (master); readers and monitors observe it (slave).
interface seven_segments_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [N_DIGITS-1:0] digit_sel;
    logic [6:0]          seg;

    modport master (output digit_sel, output seg);
    modport slave  (input  digit_sel, input  seg);
endinterface

// File: rtl/seven_segments_scan_reader.sv
// Reconstructs the hex value shown on each digit of a scanned seven-segment display.
// It filters each digit for stability, validates the pattern, latches results and flags complete frames.
//
// state  | meaning
// IDLE   | no one-hot select on the bus; no sample held
// SETTLE | a one-hot sample is held; counting consecutive identical samples
// HELD   | the held sample has been accepted; waiting for it to change
module seven_segments_scan_reader #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    seven_segments_scan_if.slave        scan,
    output logic [4*N_DIGITS-1:0]       digits,
    output logic [N_DIGITS-1:0]         digit_valid,
    output logic [N_DIGITS-1:0]         digit_blank,
    output logic                        update,
    output logic [$clog2(N_DIGITS)-1:0] update_idx,
    output logic                        bad_pattern,
    output logic                        frame_done,
    output logic [7:0]                  error_count
);
    localparam int       IDX_W    = $clog2(N_DIGITS);
    localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);
    localparam bit       ONE_SHOT = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t              state, state_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic [N_DIGITS-1:0] prev_sel, seen;
    logic [6:0]          prev_seg;
    logic                sel_ok, match, restart, load, accept;
    logic [IDX_W-1:0]    sel_idx;
    logic                dec_legal;
    logic [3:0]          dec_val;

    always_comb begin
        sel_ok  = $onehot(scan.digit_sel);
        match   = sel_ok && (scan.digit_sel == prev_sel) && (scan.seg == prev_seg);
        sel_idx = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (scan.digit_sel[i]) sel_idx = IDX_W'(i);
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (scan.seg)
            7'h7E: dec_val = 4'h0;
            7'h30: dec_val = 4'h1;
            7'h6D: dec_val = 4'h2;
            7'h79: dec_val = 4'h3;
            7'h33: dec_val = 4'h4;
            7'h5B: dec_val = 4'h5;
            7'h5F: dec_val = 4'h6;
            7'h70: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h7B: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h1F: dec_val = 4'hB;
            7'h0D: dec_val = 4'hC;
            7'h3D: dec_val = 4'hD;
            7'h4F: dec_val = 4'hE;
            7'h47: dec_val = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        restart   = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_ok) restart = 1'b1;
                else        cnt_nxt = 8'd0;
            end
            SETTLE: begin
                if (match) begin
                    if (cnt + 8'd1 == STABLE_TC) begin
                        accept    = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end else if (sel_ok) begin
                    restart = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            HELD: begin
                if (!match) begin
                    if (sel_ok) begin
                        restart = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
        // A fresh sample counts as the first of its run; with a one-sample filter it is accepted at once.
        if (restart) begin
            load    = 1'b1;
            cnt_nxt = 8'd1;
            if (ONE_SHOT) begin
                accept    = 1'b1;
                state_nxt = HELD;
            end else begin
                state_nxt = SETTLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            prev_sel    <= '0;
            prev_seg    <= '0;
            seen        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            update      <= 1'b0;
            update_idx  <= '0;
            bad_pattern <= 1'b0;
            frame_done  <= 1'b0;
            error_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            update      <= 1'b0;
            bad_pattern <= 1'b0;
            frame_done  <= 1'b0;
            if (load) begin
                prev_sel <= scan.digit_sel;
                prev_seg <= scan.seg;
            end
            if (accept) begin
                update     <= 1'b1;
                update_idx <= sel_idx;
                if (dec_legal) begin
                    digits[{sel_idx, 2'b00} +: 4] <= dec_val;
                    digit_valid[sel_idx]          <= 1'b1;
                    digit_blank[sel_idx]          <= 1'b0;
                end else if (scan.seg == 7'h00) begin
                    digit_valid[sel_idx] <= 1'b0;
                    digit_blank[sel_idx] <= 1'b1;
                end else begin
                    bad_pattern          <= 1'b1;
                    digit_valid[sel_idx] <= 1'b0;
                    digit_blank[sel_idx] <= 1'b0;
                    if (error_count != 8'hFF) error_count <= error_count + 8'd1;
                end
                if ((seen | scan.digit_sel) == {N_DIGITS{1'b1}}) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen | scan.digit_sel;
                end
            end
        end
    end
endmodule

// File: doc/seven_segments_scan_reader.md
Name: seven_segments_scan_reader

Overview:
- Receive side of the multiplexed seven-segment display interface: observes one-hot digit-select plus 7-bit segment lines and reconstructs the hex value shown on each digit.
- Inverts the team's hex-to-segment encoding, so display-driver outputs can be checked in-system and by self-checking benches.
- Includes a stability filter, pattern validation, per-digit latched results and frame-complete detection.

Parameters:
N_DIGITS, 4, number of multiplexed digits (legal range 2..8)
STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (legal range 1..255)

Ports:
clk  in  1  single clock; every register is rising-edge
rst  in  1  synchronous, active-high reset
digit_sel  in  N_DIGITS  one-hot digit select; bit i = digit i
seg  in  7  active-high segments; bit6=a, bit5=b, ..., bit0=g
digits  out  4*N_DIGITS  latched hex value; nibble i = digits[4i+3:4i]
digit_valid  out  N_DIGITS  1 = nibble i holds a decoded hex value
digit_blank  out  N_DIGITS  1 = digit i was last accepted as all-off
update  out  1  one-cycle pulse when any digit is accepted
update_idx  out  $clog2(N_DIGITS)  index of the accepted digit; meaningful only while update=1
bad_pattern  out  1  one-cycle pulse when the accepted pattern is not legal
frame_done  out  1  one-cycle pulse when every digit has been accepted since the previous frame_done or reset
error_count  out  8  count of bad_pattern events; saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0, FSM in IDLE, prev_sel/prev_seg/cnt/seen mask all 0. Reset overrides any in-progress settle, and that sample is discarded.
- Registered outputs. digit_sel/seg are sampled at each edge.
- sel_ok = digit_sel is exactly one-hot. match = sel_ok and (digit_sel,seg) equal prev_sel/prev_seg from the previous edge.
- FSM states:
  - IDLE: sel_ok=0 → stay, cnt=0. sel_ok=1 → load prev, cnt=1, go SETTLE. If STABLE_CYCLES=1, accept on this same edge and go HELD.
  - SETTLE: match and cnt+1==STABLE_CYCLES → accept, go HELD. match otherwise → cnt+1. sel_ok but no match → reload prev, cnt=1, stay (or accept immediately if STABLE_CYCLES=1). sel_ok=0 → IDLE.
  - HELD: match → stay, no re-accept. sel_ok but no match → reload, cnt=1, SETTLE (or accept immediately if STABLE_CYCLES=1). sel_ok=0 → IDLE.
- Latency: accept occurs on the STABLE_CYCLES-th consecutive equal sample edge. Results and pulses are visible in the cycle after that edge.
- Decode table (seg hex → nibble): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→B, 0D→C, 3D→D, 4F→E, 47→F.
- Accept of digit i, one of three cases:
  - Legal pattern: nibble i ← decode, valid[i]=1, blank[i]=0.
  - seg=00: blank[i]=1, valid[i]=0, nibble i unchanged.
  - Any other pattern: bad_pattern=1, valid[i]=0, blank[i]=0, nibble unchanged, error_count+1 (saturating).
- Every accept pulses update with update_idx=i and sets seen[i].
- Frame detection: when seen|accepted-bit == all-ones, pulse frame_done in the same cycle as update and clear seen to 0. Accepting the same digit twice within a frame does not advance the frame.
- Unchanged digits keep their values. Non-one-hot select never modifies any state except the FSM/cnt.

Test Plan:
- Reset, then digit_sel=0001, seg=6D held 4 cycles → update pulse visible after 4th edge, update_idx=0, digits[3:0]=2, digit_valid=0001. No further update while held 10 more cycles.
- digit_sel=0010 with seg toggling 79/33 every 2 cycles (STABLE_CYCLES=4) → no update. Then hold 33 for 4 cycles → digits[7:4]=4.
- Scan digits 0..3 with patterns 7E, 30, 47, 00, each held 5 cycles → digits=x_F_1_0 (digit 3 nibble unchanged), valid=0111, blank=1000, frame_done with the digit-3 update pulse.
- seg=7C on digit 2, held 4 cycles → bad_pattern pulse, valid[2]=0, error_count=1. Repeat 300 such accepts → error_count=255.
- digit_sel=0110 or 0000 held 20 cycles with any seg → no update, outputs unchanged. Assert rst mid-settle (after 2 cycles of 5B) → all outputs 0, and the next 4-cycle hold of 5B yields digit=5.
- STABLE_CYCLES=1 build: seg sequence 30, 6D, 6D, 79 on digit 0 → three update pulses (for 1, 2, 3), no re-accept on the repeated 6D.
